// File: rtl/imem_program_loader_if.sv
// rtl/imem_program_loader_if.sv - byte-stream input and IMEM write port bundle for the program loader
//
// Purpose:
//   Groups the loader's byte-stream handshake and its instruction-memory
//   write port so the top level can hand one bundle to the loader.
//
// Signals:
//   in_valid    1   byte-stream valid (source -> loader)
//   in_data     8   byte-stream payload (source -> loader)
//   in_ready    1   loader can accept a byte this cycle (loader -> source)
//   imem_we     1   instruction-memory write strobe (loader -> IMEM mux)
//   imem_addr   32  word-aligned byte address of the write (loader -> IMEM mux)
//   imem_wdata  32  instruction word to write (loader -> IMEM mux)
//
// Modports:
//   master  loader side: consumes the stream, drives the IMEM write port
//   slave   environment side: produces the stream, observes the writes

interface imem_program_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - loads a byte-streamed program into instruction memory while holding the core
//
// Purpose:
//   Receives a 2-byte big-endian word count N followed by N big-endian
//   32-bit MIPS words, writes each word into instruction memory at
//   BASE_ADDR + 4*k, and holds the core (cpu_hold) for the whole load.
//
// Optional feature (macro LOADER_CHECKSUM_EN):
//   When defined, a running XOR of every data byte is kept and one extra
//   checksum byte is accepted after the last word; a mismatch sets err.
//   When undefined, the checksum state and register are not built.
//
// Parameters:
//   BASE_ADDR   byte address of the first written word (word-aligned)
//   MAX_WORDS   largest accepted word count; larger headers are rejected
//
// Ports:
//   clk            in   1   system clock, rising edge
//   reset          in   1   synchronous, active-high reset
//   start          in   1   one-cycle load request, honoured only in IDLE
//   bus            if       byte stream in, IMEM write port out (master)
//   cpu_hold       out  1   freeze request to the core during a load
//   busy           out  1   high whenever the loader is not idle
//   done           out  1   one-cycle pulse at the end of a load
//   err            out  1   sticky error, cleared by the next accepted start
//   words_loaded   out  16  words written in the current or last load

module imem_program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    imem_program_loader_if.master  bus,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [15:0]            words_loaded
);

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    // S_FLUSH covers the cycle in which the final write strobe is on the
    // bus, so cpu_hold only drops once that write has landed.
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_FLUSH,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] count_q, count_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [23:0] shift_q, shift_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        hold_q, hold_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] words_q, words_d;

    logic        in_ready;
    logic        xfer;
    logic [15:0] hdr_count;

    // Ready is a pure function of state so a presented byte is never dropped.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_HDR:   in_ready = 1'b1;
            S_DATA:  in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:   in_ready = 1'b1;
`endif
            default: in_ready = 1'b0;
        endcase
    end

    assign xfer      = bus.in_valid && in_ready;
    assign hdr_count = {count_q[15:8], bus.in_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_idx_q <= 2'd0;
            count_q    <= 16'd0;
            word_idx_q <= 16'd0;
            shift_q    <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            hold_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            shift_q    <= shift_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            words_q    <= words_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        shift_d    = shift_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        words_d    = words_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_HDR;
                    byte_idx_d = 2'd0;
                    word_idx_d = 16'd0;
                    err_d      = 1'b0;
                    words_d    = 16'd0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                end
            end

            S_HDR: begin
                if (xfer) begin
                    if (byte_idx_q == 2'd0) begin
                        count_d[15:8] = bus.in_data;
                        byte_idx_d    = 2'd1;
                    end else begin
                        count_d    = hdr_count;
                        byte_idx_d = 2'd0;
                        if (hdr_count == 16'd0 || {1'b0, hdr_count} > MAX_W) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.in_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        we_d       = 1'b1;
                        wdata_d    = {shift_q, bus.in_data};
                        addr_d     = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                        words_d    = words_q + 16'd1;
                        word_idx_d = word_idx_q + 16'd1;
                        byte_idx_d = 2'd0;
                        if (word_idx_q == count_q - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d = S_FLUSH;
`endif
                        end
                    end else begin
                        shift_d    = {shift_q[15:0], bus.in_data};
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end

`ifdef LOADER_CHECKSUM_EN
            // The last write has already been issued; a bad checksum only flags the load.
            S_CHK: begin
                if (xfer) begin
                    if (bus.in_data != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
`endif

            S_FLUSH: begin
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the state being entered.
        hold_d = (state_d != S_IDLE) && (state_d != S_DONE);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_hold       = hold_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign words_loaded   = words_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - directed self-checking bench for imem_program_loader

module tb_imem_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    imem_program_loader_if bus ();

    imem_program_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (256)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          done_cnt;
    int          done_cyc;
    int          hold_fall_cyc;
    int          last_hs_cyc;
    logic        prev_hold = 1'b0;
    logic [7:0]  stim[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_hold && !cpu_hold) hold_fall_cyc = cyc;
        prev_hold = cpu_hold;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt      = 0;
        done_cyc      = -1;
        hold_fall_cyc = -1;
        last_hs_cyc   = -1;
    endtask

    task automatic good_stream();
        stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(8'h0E);
`endif
    endtask

    task automatic do_start(input string pfx);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({pfx, "_hold_after_start"}, {31'd0, cpu_hold}, 32'd1);
        check({pfx, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        check({pfx, "_err_after_start"}, {31'd0, err}, 32'd0);
        check({pfx, "_words_after_start"}, {16'd0, words_loaded}, 32'd0);
    endtask

    // gap=1 drops in_valid every other cycle; start is pulsed while byte start_at is offered.
    task automatic send_stream(input bit gap, input int start_at);
        int idx    = 0;
        int budget = 0;
        int phase  = 0;
        while (idx < stim.size() && budget < 400) begin
            @(negedge clk);
            start = (idx == start_at);
            if (gap && phase[0]) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = stim[idx];
            end
            phase++;
            budget++;
            if (bus.in_valid && bus.in_ready) begin
                last_hs_cyc = cyc;
                idx++;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        start        = 1'b0;
        if (idx < stim.size()) check("stream_timeout", idx, stim.size());
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_good_load(input string pfx, input bit full_rate);
        check({pfx, "_nwrites"}, wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            check({pfx, "_addr0"}, wr_addr[0], 32'h0000_0000);
            check({pfx, "_data0"}, wr_data[0], 32'h2008_0005);
            check({pfx, "_addr1"}, wr_addr[1], 32'h0000_0004);
            check({pfx, "_data1"}, wr_data[1], 32'h2009_000A);
            if (full_rate) begin
                check({pfx, "_we_spacing"}, wr_cyc[1] - wr_cyc[0], 32'd4);
                check({pfx, "_hold_fall"}, hold_fall_cyc, wr_cyc[1] + 1);
            end
        end
        check({pfx, "_done_cnt"}, done_cnt, 32'd1);
        check({pfx, "_words"}, {16'd0, words_loaded}, 32'd2);
        check({pfx, "_err"}, {31'd0, err}, 32'd0);
        check({pfx, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({pfx, "_hold_end"}, {31'd0, cpu_hold}, 32'd0);
    endtask

    task automatic bad_header(input string pfx, input logic [7:0] hi, input logic [7:0] lo);
        clear_log();
        stim = '{hi, lo};
        do_start(pfx);
        send_stream(1'b0, -1);
        wait_idle();
        check({pfx, "_nwrites"}, wr_addr.size(), 32'd0);
        check({pfx, "_err"}, {31'd0, err}, 32'd1);
        check({pfx, "_done_cnt"}, done_cnt, 32'd1);
        check({pfx, "_done_timing"}, done_cyc, last_hs_cyc + 1);
        check({pfx, "_words"}, {16'd0, words_loaded}, 32'd0);
        repeat (3) @(negedge clk);
        check({pfx, "_err_sticky"}, {31'd0, err}, 32'd1);
    endtask

    initial begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        clear_log();

        // reset with in_valid held high, then a few IDLE cycles
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 3) reset = 1'b0;
            check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("rst_we", {31'd0, bus.imem_we}, 32'd0);
            check("rst_hold", {31'd0, cpu_hold}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
        end
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);
        check("rst_no_writes", wr_addr.size(), 32'd0);
        bus.in_valid = 1'b0;

        // full-rate two-word load
        clear_log();
        good_stream();
        do_start("full");
        send_stream(1'b0, -1);
        wait_idle();
        check_good_load("full", 1'b1);

        // gapped load with a stray start pulse mid-stream
        clear_log();
        good_stream();
        do_start("gap");
        send_stream(1'b1, 5);
        wait_idle();
        check_good_load("gap", 1'b0);

        // illegal header counts
        bad_header("hdr0", 8'h00, 8'h00);
        bad_header("hdr257", 8'h01, 8'h01);

        // a fresh start after an error load clears err and loads normally
        clear_log();
        good_stream();
        do_start("after_err");
        send_stream(1'b0, -1);
        wait_idle();
        check_good_load("after_err", 1'b1);

        // reset after two bytes of the second word
        clear_log();
        stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09};
        do_start("midrst");
        send_stream(1'b0, -1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hold", {31'd0, cpu_hold}, 32'd0);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("midrst_words", {16'd0, words_loaded}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_idle_ready", {31'd0, bus.in_ready}, 32'd0);
        check("midrst_nwrites", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            check("midrst_addr0", wr_addr[0], 32'h0000_0000);
            check("midrst_data0", wr_data[0], 32'h2008_0005);
        end
        check("midrst_done_cnt", done_cnt, 32'd0);

        clear_log();
        good_stream();
        do_start("reload");
        send_stream(1'b0, -1);
        wait_idle();
        check_good_load("reload", 1'b1);

`ifdef LOADER_CHECKSUM_EN
        // one word 8C100000: XOR of its bytes is 9C
        clear_log();
        stim = '{8'h00, 8'h01, 8'h8C, 8'h10, 8'h00, 8'h00, 8'h9C};
        do_start("csum_ok");
        send_stream(1'b0, -1);
        wait_idle();
        check("csum_ok_nwrites", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            check("csum_ok_addr", wr_addr[0], 32'h0000_0000);
            check("csum_ok_data", wr_data[0], 32'h8C10_0000);
        end
        check("csum_ok_err", {31'd0, err}, 32'd0);
        check("csum_ok_done", done_cnt, 32'd1);

        clear_log();
        stim = '{8'h00, 8'h01, 8'h8C, 8'h10, 8'h00, 8'h00, 8'h00};
        do_start("csum_bad");
        send_stream(1'b0, -1);
        wait_idle();
        check("csum_bad_nwrites", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            check("csum_bad_addr", wr_addr[0], 32'h0000_0000);
            check("csum_bad_data", wr_data[0], 32'h8C10_0000);
        end
        check("csum_bad_err", {31'd0, err}, 32'd1);
        check("csum_bad_done", done_cnt, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer-side counterpart to the bench's register/PC readout: pushes a program into instruction memory so the pipelined core can run it without a hard-coded memory init.
- Accepts a byte stream (valid/ready), assembles big-endian 32-bit MIPS words and issues instruction-memory writes.
- Holds the core (cpu_hold) while loading.
- Sits beside the core's instruction memory; the write port is muxed in front of the IMEM by the top level.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be word-aligned.
- MAX_WORDS, 256, largest accepted word count; the header is rejected above this.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; ignored unless in IDLE.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream payload.
- in_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  32  byte address of the write; word-aligned.
- imem_wdata  output  32  instruction word.
- cpu_hold  output  1  stall/freeze request to the core.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of a load.
- err  output  1  sticky error flag; cleared on the next accepted start.
- words_loaded  output  16  count of words written in the current or last load.

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - All outputs 0.
  - FSM in IDLE; byte index, word counter and checksum cleared.
- Byte transfer: a byte is transferred only on a cycle with in_valid && in_ready.
  - in_ready is 1 in HDR, DATA and CHK states and 0 otherwise.
  - The loader never drops a presented byte: in_ready depends only on state.
- FSM transitions:
  - IDLE: start=1 -> HDR. cpu_hold, busy and err are registered 1, 1 and 0 on that edge; words_loaded is cleared.
  - HDR: takes 2 bytes forming word count N, big-endian, first byte = N[15:8].
    - After the 2nd byte, if N==0 or N>MAX_WORDS: set err=1 and go to DONE.
    - Otherwise go to DATA.
  - DATA: takes 4 bytes per word, first byte = word[31:24].
    - The edge accepting the 4th byte registers imem_we=1 for exactly the next cycle.
    - On that write, imem_addr = BASE_ADDR + 4*k, where k is the 0-based word index, and imem_wdata = the assembled word.
    - words_loaded increments on the same edge that asserts imem_we.
    - When k reaches N-1, the next state is CHK if the optional feature is compiled in, otherwise DONE.
  - CHK: see Optional Feature.
  - DONE: lasts one cycle.
    - done=1 and cpu_hold=0 (registered on entry, so cpu_hold falls the cycle after the last imem_we).
    - busy=0 from the following cycle.
    - Next state is IDLE.
- Write latency: 1 cycle from the 4th-byte handshake to imem_we.
  - Back-to-back words at full rate give imem_we once every 4 cycles.
- start asserted outside IDLE is ignored with no side effects.
- in_valid in IDLE/DONE: not accepted, because in_ready=0.
- Address arithmetic is 32-bit modulo; no wrap check beyond MAX_WORDS.
- reset mid-load:
  - Returns to IDLE immediately with all outputs at their reset values.
  - A partial word is discarded and never written.
  - Writes already performed stay in memory.
- err stays high after DONE until the next accepted start.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps a running XOR of every DATA byte.
  - After the last word, state CHK accepts 1 byte.
  - If that byte differs from the XOR, err=1; either way go to DONE.
  - All words are already written by then; err only flags the load as bad.
- Undefined:
  - The CHK state and checksum register do not exist.
  - DATA goes straight to DONE after the last word.
  - err is set only by an illegal header count.

Test Plan:
- Reset with in_valid=1 -> in_ready=0, imem_we=0, cpu_hold=0, busy=0 throughout reset and IDLE.
- start, bytes 00 02 20 08 00 05 20 09 00 0A at full rate:
  - write 0x20080005 @0x00000000, then 0x2009000A @0x00000004;
  - done pulses once, words_loaded=2, cpu_hold falls 1 cycle after the second imem_we, err=0.
- Same stream with in_valid deasserted every other cycle -> identical writes, addresses and data; only timing stretches; no byte lost or duplicated.
- Header 00 00, and separately header 01 01 with MAX_WORDS=256 -> no imem_we; err=1; done pulses 1 cycle after the 2nd header byte.
- reset asserted after 2 bytes of the second word -> only the 0x00000000 write occurs, FSM in IDLE; a fresh start then loads correctly with err cleared.
- LOADER_CHECKSUM_EN, 1 word 8C 10 00 00:
  - checksum byte 9C -> err=0;
  - checksum byte 00 -> err=1;
  - in both cases the word is written @0x00000000 and done pulses.
